// File: rtl/cnn_pkg.sv
// Shared types and default dimensions for the flattening stage between pooling and the dense layer.
package cnn_pkg;

  localparam int DEF_NUM_FEATURES           = 10;
  localparam int DEF_POOLED_HEIGHT          = 10;
  localparam int DEF_POOLED_WIDTH           = 10;
  localparam int DEF_CONVOLUTION_DATA_WIDTH = 8;
  localparam int DEF_FLATTENED_LENGTH       = DEF_NUM_FEATURES * DEF_POOLED_HEIGHT * DEF_POOLED_WIDTH;
  localparam int DEF_ADDR_WIDTH             = $clog2(DEF_FLATTENED_LENGTH);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } flat_state_t;

  typedef struct packed {
    logic [DEF_CONVOLUTION_DATA_WIDTH-1:0] data;
    logic [DEF_ADDR_WIDTH-1:0]             index;
  } flat_entry_t;

  // Counter width for a modulus n, never narrower than one bit.
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/flatten_skid_fifo.sv
// Two-entry skid FIFO: head is visible combinationally, push and pop same cycle, zero-latency pop.
// A push into a full FIFO is only accepted together with a pop; count is then unchanged.
module flatten_skid_fifo #(
  parameter type entry_t = cnn_pkg::flat_entry_t
) (
  input  logic       clock_i,
  input  logic       reset_n_i,
  input  logic       push_i,
  input  entry_t     push_entry_i,
  input  logic       pop_i,
  output entry_t     head_o,
  output logic       full_o,
  output logic       empty_o,
  output logic [1:0] count_o
);

  entry_t     mem_q [2];
  logic       wr_ptr_q, rd_ptr_q;
  logic [1:0] count_q, count_d;
  logic       do_push, do_pop;

  assign full_o  = (count_q == 2'd2);
  assign empty_o = (count_q == 2'd0);
  assign count_o = count_q;
  assign head_o  = mem_q[rd_ptr_q];

  assign do_pop  = pop_i & ~empty_o;
  assign do_push = push_i & (~full_o | do_pop);

  always_comb begin
    count_d = count_q + {1'b0, do_push} - {1'b0, do_pop};
  end

  always_ff @(posedge clock_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      mem_q[0] <= '0;
      mem_q[1] <= '0;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      if (do_push) begin
        mem_q[wr_ptr_q] <= push_entry_i;
        wr_ptr_q        <= ~wr_ptr_q;
      end
      if (do_pop) begin
        rd_ptr_q <= ~rd_ptr_q;
      end
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/flatten_sequencer.sv
// Walks the pooled maps, reads the 1-cycle RAM and streams a flattened vector over valid/ready.
// Reads are throttled so FIFO entries plus in-flight reads never exceed 2; FLATTEN_CHANNEL_LAST_EN selects HWC walk order.
module flatten_sequencer #(
  parameter int NUM_FEATURES           = cnn_pkg::DEF_NUM_FEATURES,
  parameter int POOLED_HEIGHT          = cnn_pkg::DEF_POOLED_HEIGHT,
  parameter int POOLED_WIDTH           = cnn_pkg::DEF_POOLED_WIDTH,
  parameter int FLATTENED_LENGTH       = NUM_FEATURES * POOLED_HEIGHT * POOLED_WIDTH,
  parameter int CONVOLUTION_DATA_WIDTH = cnn_pkg::DEF_CONVOLUTION_DATA_WIDTH,
  parameter int ADDR_WIDTH             = $clog2(FLATTENED_LENGTH)
) (
  input  logic                              clock,
  input  logic                              reset_n,
  input  logic                              flatten_start,
  output logic                              pool_rd_en,
  output logic [ADDR_WIDTH-1:0]             pool_rd_addr,
  input  logic [CONVOLUTION_DATA_WIDTH-1:0] pool_rd_data,
  output logic                              flat_valid,
  input  logic                              flat_ready,
  output logic [CONVOLUTION_DATA_WIDTH-1:0] flat_data,
  output logic [ADDR_WIDTH-1:0]             flat_index,
  output logic                              flatten_busy,
  output logic                              flatten_done
);
  import cnn_pkg::*;

  localparam int FW       = cnt_width(NUM_FEATURES);
  localparam int RW       = cnt_width(POOLED_HEIGHT);
  localparam int CW       = cnt_width(POOLED_WIDTH);
  localparam int MAP_SIZE = POOLED_HEIGHT * POOLED_WIDTH;

  typedef struct packed {
    logic [CONVOLUTION_DATA_WIDTH-1:0] data;
    logic [ADDR_WIDTH-1:0]             index;
  } entry_t;

  flat_state_t           state_q, state_d;
  logic [FW-1:0]         feat_q, feat_d;
  logic [RW-1:0]         row_q, row_d;
  logic [CW-1:0]         col_q, col_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d, ret_idx_q, ret_idx_d;
  logic                  inflight_q;
  logic                  fifo_full, fifo_empty, pop, can_issue;
  logic                  feat_last, row_last, col_last, is_last;
  logic [1:0]            fifo_count;
  logic [2:0]            occ;
  entry_t                push_entry, head;

  assign feat_last = (feat_q == FW'(NUM_FEATURES - 1));
  assign row_last  = (row_q == RW'(POOLED_HEIGHT - 1));
  assign col_last  = (col_q == CW'(POOLED_WIDTH - 1));
  assign is_last   = feat_last & row_last & col_last;

  assign pop = ~fifo_empty & flat_ready;
  assign occ = {1'b0, fifo_count} + {2'b0, inflight_q};

  // An entry leaving this cycle frees room for a new read.
  always_comb begin
    if (fifo_full) can_issue = pop & ~inflight_q;
    else           can_issue = (occ < 3'd2) || ((occ == 3'd2) && pop);
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state_q <= IDLE;
    else          state_q <= state_d;
  end

  // DRAIN also exits on the final pop itself so done lands one cycle after the last handshake.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (flatten_start) state_d = RUN;
      RUN:     if (pool_rd_en && is_last) state_d = DRAIN;
      DRAIN:   if (!inflight_q && (fifo_empty || (fifo_count == 2'd1 && pop))) state_d = DONE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    pool_rd_en   = (state_q == RUN) && can_issue;
    flatten_busy = (state_q != IDLE);
    flatten_done = (state_q == DONE);
  end

  always_comb begin
    feat_d    = feat_q;
    row_d     = row_q;
    col_d     = col_q;
    addr_d    = addr_q;
    ret_idx_d = inflight_q ? ret_idx_q + 1'b1 : ret_idx_q;
    if (state_q == IDLE) begin
      feat_d    = '0;
      row_d     = '0;
      col_d     = '0;
      addr_d    = '0;
      ret_idx_d = '0;
    end else if (pool_rd_en) begin
`ifdef FLATTEN_CHANNEL_LAST_EN
      // Feature innermost: hop one map per step, rewind to the next pixel of map 0 on wrap.
      if (feat_last) begin
        feat_d = '0;
        addr_d = addr_q - ADDR_WIDTH'((NUM_FEATURES - 1) * MAP_SIZE) + 1'b1;
        if (col_last) begin
          col_d = '0;
          row_d = row_last ? '0 : row_q + 1'b1;
        end else begin
          col_d = col_q + 1'b1;
        end
      end else begin
        feat_d = feat_q + 1'b1;
        addr_d = addr_q + ADDR_WIDTH'(MAP_SIZE);
      end
`else
      addr_d = addr_q + 1'b1;
      if (col_last) begin
        col_d = '0;
        if (row_last) begin
          row_d  = '0;
          feat_d = feat_last ? '0 : feat_q + 1'b1;
        end else begin
          row_d = row_q + 1'b1;
        end
      end else begin
        col_d = col_q + 1'b1;
      end
`endif
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      feat_q     <= '0;
      row_q      <= '0;
      col_q      <= '0;
      addr_q     <= '0;
      ret_idx_q  <= '0;
      inflight_q <= 1'b0;
    end else begin
      feat_q     <= feat_d;
      row_q      <= row_d;
      col_q      <= col_d;
      addr_q     <= addr_d;
      ret_idx_q  <= ret_idx_d;
      inflight_q <= pool_rd_en;
    end
  end

  assign push_entry.data  = pool_rd_data;
  assign push_entry.index = ret_idx_q;

  flatten_skid_fifo #(.entry_t(entry_t)) u_fifo (
    .clock_i      (clock),
    .reset_n_i    (reset_n),
    .push_i       (inflight_q),
    .push_entry_i (push_entry),
    .pop_i        (pop),
    .head_o       (head),
    .full_o       (fifo_full),
    .empty_o      (fifo_empty),
    .count_o      (fifo_count)
  );

  assign pool_rd_addr = addr_q;
  assign flat_valid   = ~fifo_empty;
  assign flat_data    = head.data;
  assign flat_index   = head.index;

endmodule

// File: tb/tb_flatten_sequencer.sv
// Bench for flatten_sequencer: a 2x2x3 instance and a default 10x10x10 instance share clock and reset.
// Expected addresses/data come from the walk-order rules; build with +define+FLATTEN_CHANNEL_LAST_EN for HWC.
module tb_flatten_sequencer;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic reset_n, ready, s_start, b_start;

  logic       s_rd_en, s_valid, s_busy, s_done;
  logic [3:0] s_addr, s_idx;
  logic [7:0] s_rd_data, s_data;

  logic       b_rd_en, b_valid, b_busy, b_done;
  logic [9:0] b_addr, b_idx;
  logic [7:0] b_rd_data, b_data;

  logic [7:0] ram [1024];
  int total = 0;
  int bad   = 0;
  bit sel;
  int cur_f, cur_h, cur_w;

  flatten_sequencer #(.NUM_FEATURES(2), .POOLED_HEIGHT(2), .POOLED_WIDTH(3)) u_small (
    .clock(clock), .reset_n(reset_n), .flatten_start(s_start),
    .pool_rd_en(s_rd_en), .pool_rd_addr(s_addr), .pool_rd_data(s_rd_data),
    .flat_valid(s_valid), .flat_ready(ready), .flat_data(s_data), .flat_index(s_idx),
    .flatten_busy(s_busy), .flatten_done(s_done)
  );

  flatten_sequencer u_big (
    .clock(clock), .reset_n(reset_n), .flatten_start(b_start),
    .pool_rd_en(b_rd_en), .pool_rd_addr(b_addr), .pool_rd_data(b_rd_data),
    .flat_valid(b_valid), .flat_ready(ready), .flat_data(b_data), .flat_index(b_idx),
    .flatten_busy(b_busy), .flatten_done(b_done)
  );

  // Pooled RAM: one-cycle read latency.
  initial begin
    s_rd_data = '0;
    b_rd_data = '0;
  end
  always @(posedge clock) begin
    if (s_rd_en) s_rd_data <= ram[s_addr];
    if (b_rd_en) b_rd_data <= ram[b_addr];
  end

  logic        o_rd_en, o_valid, o_busy, o_done;
  logic [31:0] o_addr, o_idx;
  logic [7:0]  o_data;
  always_comb begin
    o_rd_en = sel ? b_rd_en : s_rd_en;
    o_valid = sel ? b_valid : s_valid;
    o_busy  = sel ? b_busy  : s_busy;
    o_done  = sel ? b_done  : s_done;
    o_addr  = sel ? 32'(b_addr) : 32'(s_addr);
    o_idx   = sel ? 32'(b_idx)  : 32'(s_idx);
    o_data  = sel ? b_data : s_data;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0d want %0d", tag, obs, exp);
    end
  endtask

  // RAM address of the k-th element in walk order.
  function automatic int exp_addr(input int k);
`ifdef FLATTEN_CHANNEL_LAST_EN
    int f, r, c;
    f = k % cur_f;
    c = (k / cur_f) % cur_w;
    r = k / (cur_f * cur_w);
    return f * cur_h * cur_w + r * cur_w + c;
`else
    return k;
`endif
  endfunction

  task automatic set_sel(input bit which);
    sel = which;
    if (which) begin cur_f = 10; cur_h = 10; cur_w = 10; end
    else       begin cur_f = 2;  cur_h = 2;  cur_w = 3;  end
  endtask

  task automatic chk_zero_outputs(input string tag);
    chk({tag, "_s_rd_en"}, s_rd_en, 0); chk({tag, "_s_addr"}, s_addr, 0);
    chk({tag, "_s_valid"}, s_valid, 0); chk({tag, "_s_data"}, s_data, 0);
    chk({tag, "_s_idx"}, s_idx, 0);     chk({tag, "_s_busy"}, s_busy, 0);
    chk({tag, "_s_done"}, s_done, 0);
    chk({tag, "_b_rd_en"}, b_rd_en, 0); chk({tag, "_b_addr"}, b_addr, 0);
    chk({tag, "_b_valid"}, b_valid, 0); chk({tag, "_b_data"}, b_data, 0);
    chk({tag, "_b_idx"}, b_idx, 0);     chk({tag, "_b_busy"}, b_busy, 0);
    chk({tag, "_b_done"}, b_done, 0);
  endtask

  // mode 0: ready held high; 1: ready 1,0,0,1 repeating; 2: random ready.
  // Called at a falling edge; returns at a falling edge.
  task automatic run_frame(input int mode, input int restart_at, input int abort_after);
    int  len, budget, issued, popped, done_cnt, first_v, last_pop;
    bit  rdy, st, pop, prev_stall, post, fin;
    len = cur_f * cur_h * cur_w;
    budget = len * 6 + 50;
    issued = 0; popped = 0; done_cnt = 0; first_v = -1; last_pop = -1;
    prev_stall = 0; post = 0; fin = 0;
    for (int c = 0; c < budget && !fin; c++) begin
      case (mode)
        0:       rdy = 1'b1;
        1:       rdy = (c % 4 == 0) || (c % 4 == 3);
        default: rdy = ($urandom_range(0, 2) != 0);
      endcase
      st = (c == 0) || (c == restart_at);
      ready = rdy;
      if (sel) b_start = st; else s_start = st;
      #1;
      if (post) begin
        chk("idle_busy", o_busy, 0);
        chk("idle_done", o_done, 0);
        fin = 1;
      end else begin
        chk("busy", o_busy, (c >= 1) ? 1 : 0);
        if (prev_stall) chk("stall_valid_held", o_valid, 1);
        if (o_valid) begin
          // start is captured at the edge ending cycle 0; valid rises two edges later
          if (first_v < 0) begin first_v = c; chk("first_valid_latency", c, 3); end
          chk("flat_index", o_idx, popped);
          chk("flat_data", o_data, ram[exp_addr(popped)]);
        end
        pop = o_valid && rdy;
        if (o_rd_en) begin
          chk("rd_addr", o_addr, exp_addr(issued));
          chk("no_issue_when_two_outstanding", ((issued - popped - int'(pop)) < 2) ? 1 : 0, 1);
          issued++;
        end
        if (o_done) begin
          done_cnt++;
          chk("done_one_after_last", c, last_pop + 1);
          chk("done_all_popped", popped, len);
          post = 1;
        end
        if (pop) begin
          if (mode == 0) chk("throughput", c, first_v + popped);
          popped++;
          last_pop = c;
        end
        prev_stall = o_valid && !rdy;
        if (abort_after > 0 && popped == abort_after) fin = 1;
      end
      @(negedge clock);
    end
    s_start = 1'b0;
    b_start = 1'b0;
    if (abort_after == 0) begin
      chk("done_count", done_cnt, 1);
      chk("issued_total", issued, len);
      chk("popped_total", popped, len);
    end
  endtask

  initial begin
    reset_n = 1'b0;
    ready   = 1'b0;
    s_start = 1'b0;
    b_start = 1'b0;
    set_sel(0);
    for (int i = 0; i < 1024; i++) ram[i] = 8'(i + 5);

    repeat (2) @(negedge clock);
    #1;
    chk_zero_outputs("reset");
    @(negedge clock);
    reset_n = 1'b1;
    @(negedge clock);

    run_frame(0, -1, 0);
    run_frame(1, -1, 0);
    run_frame(0, 5, 0);
    for (int i = 0; i < 1024; i++) ram[i] = 8'($urandom);
    run_frame(2, 7, 0);

    // Abort mid-frame with reset, then restart clean.
    for (int i = 0; i < 1024; i++) ram[i] = 8'(i + 5);
    run_frame(0, -1, 5);
    reset_n = 1'b0;
    #1;
    chk_zero_outputs("midreset");
    @(negedge clock);
    #1;
    chk_zero_outputs("midreset_hold");
    @(negedge clock);
    reset_n = 1'b1;
    @(negedge clock);
    run_frame(0, -1, 0);

    set_sel(1);
    run_frame(0, -1, 0);
    for (int i = 0; i < 1024; i++) ram[i] = 8'($urandom);
    run_frame(2, -1, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
